// File: rtl/trigger_capture_pkg.sv
// Shared types for the trigger capture stage: FSM state encoding and counter width.
package trigger_capture_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    CAPTURE,
    HOLDOFF
  } state_t;

endpackage

// File: rtl/axis_out_reg.sv
// One-deep AXI-Stream output register with load/accept/abort; 1-cycle latency from load to tvalid.
// Source cannot stall: a load while full and not accepted flags overrun, drops the beat and empties the register.
module axis_out_reg #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IN_W-1:0]  load_data,
  input  logic             load_last,
  input  logic             abort,
  input  logic             tready,
  output logic             tvalid,
  output logic             tlast,
  output logic [OUT_W-1:0] tdata,
  output logic             full,
  output logic             overrun
);

  logic accept;

  assign accept  = tvalid & tready;
  assign overrun = load & tvalid & ~tready;
  assign full    = tvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
      tdata  <= '0;
    end else if (abort || overrun) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (load) begin
      // Simultaneous accept and load: the new beat simply replaces the accepted one.
      tvalid <= 1'b1;
      tlast  <= load_last;
      tdata  <= OUT_W'(load_data);
    end else if (accept) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end
  end

endmodule

// File: rtl/trigger_capture.sv
// Forwards SAMPLES_PER_TRIGGER ADC beats per armed trigger edge, then holds tvalid low for a holdoff gap.
// 1-cycle latency; ADC never stalled, so downstream backpressure aborts the burst as overrun. TRIGGER_CAPTURE_STATS_EN adds counters.
module trigger_capture
  import trigger_capture_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int SAMPLES_PER_TRIGGER    = 1024,
  parameter int TRIG_DELAY             = 0,
  parameter int HOLDOFF_CYCLES         = 16
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_areset,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  output logic                                s00_axis_tready,
  input  logic                                trig_in,
  input  logic                                enable,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                busy,
  output logic                                trig_missed,
  output logic                                overrun
`ifdef TRIGGER_CAPTURE_STATS_EN
  ,
  output logic [15:0]                         burst_count,
  output logic [15:0]                         missed_count
`endif
);

  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(SAMPLES_PER_TRIGGER - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(TRIG_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             trig_prev;
  logic             trig_edge;
  logic             load;
  logic             last_beat;
  logic             out_full;
  logic             ovf;

  assign s00_axis_tready = 1'b1;
  assign m00_axis_tstrb  = '1;
  assign trig_edge       = trig_in & ~trig_prev;

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // One counter serves as delay beat count, burst beat index and holdoff timer.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (trig_edge && enable) begin
          state_nxt = (TRIG_DELAY > 0) ? DELAY : CAPTURE;
        end
      end
      DELAY: begin
        if (s00_axis_tvalid) begin
          if (cnt == DLY_LAST) begin
            state_nxt = CAPTURE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (ovf) begin
          state_nxt = HOLDOFF;
          cnt_nxt   = '0;
        end else if (s00_axis_tvalid) begin
          if (cnt == BEAT_LAST) begin
            state_nxt = HOLDOFF;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      HOLDOFF: begin
        if (!out_full) begin
          if (cnt == HOLD_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    load      = (state == CAPTURE) && s00_axis_tvalid;
    last_beat = (cnt == BEAT_LAST);
    busy      = (state != IDLE) || out_full;
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      trig_prev   <= 1'b0;
      trig_missed <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      trig_prev   <= trig_in;
      trig_missed <= trig_edge && (state != IDLE);
      overrun     <= overrun | ovf;
    end
  end

  axis_out_reg #(
    .IN_W  (C_S00_AXIS_TDATA_WIDTH),
    .OUT_W (C_M00_AXIS_TDATA_WIDTH)
  ) u_out_reg (
    .clk       (s00_axis_aclk),
    .rst       (s00_axis_areset),
    .load      (load),
    .load_data (s00_axis_tdata),
    .load_last (last_beat),
    .abort     (1'b0),
    .tready    (m00_axis_tready),
    .tvalid    (m00_axis_tvalid),
    .tlast     (m00_axis_tlast),
    .tdata     (m00_axis_tdata),
    .full      (out_full),
    .overrun   (ovf)
  );

`ifdef TRIGGER_CAPTURE_STATS_EN
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      burst_count  <= '0;
      missed_count <= '0;
    end else begin
      if (m00_axis_tvalid && m00_axis_tready && m00_axis_tlast) begin
        burst_count <= burst_count + 1'b1;
      end
      if (trig_missed && (missed_count != 16'hFFFF)) begin
        missed_count <= missed_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_trigger_capture.sv
// Randomized scoreboard bench for trigger_capture: a transaction-level model queues expected beats, a monitor checks handshakes.
module tb_trigger_capture;

  localparam int IW   = 16;
  localparam int OW   = 32;
  localparam int SPT  = 8;
  localparam int DLY  = 3;
  localparam int HOLD = 16;

  typedef struct packed {
    logic [OW-1:0] dat;
    logic          last;
  } beat_t;

  typedef enum int {M_IDLE, M_SKIP, M_TAKE, M_REST} mphase_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_vld;
  logic [IW-1:0]   s_dat;
  logic            s_rdy;
  logic            trig;
  logic            en;
  logic            m_rdy;
  logic            m_vld;
  logic            m_last;
  logic [OW-1:0]   m_dat;
  logic [OW/8-1:0] m_strb;
  logic            busy;
  logic            trig_missed;
  logic            overrun;
`ifdef TRIGGER_CAPTURE_STATS_EN
  logic [15:0]     burst_count;
  logic [15:0]     missed_count;
`endif

  always #5 clk = ~clk;

  trigger_capture #(
    .C_S00_AXIS_TDATA_WIDTH (IW),
    .C_M00_AXIS_TDATA_WIDTH (OW),
    .SAMPLES_PER_TRIGGER    (SPT),
    .TRIG_DELAY             (DLY),
    .HOLDOFF_CYCLES         (HOLD)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tvalid (s_vld),
    .s00_axis_tdata  (s_dat),
    .s00_axis_tready (s_rdy),
    .trig_in         (trig),
    .enable          (en),
    .m00_axis_tready (m_rdy),
    .m00_axis_tvalid (m_vld),
    .m00_axis_tlast  (m_last),
    .m00_axis_tdata  (m_dat),
    .m00_axis_tstrb  (m_strb),
    .busy            (busy),
    .trig_missed     (trig_missed),
    .overrun         (overrun)
`ifdef TRIGGER_CAPTURE_STATS_EN
    ,
    .burst_count     (burst_count),
    .missed_count    (missed_count)
`endif
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: phases of a burst, counted down in beats/cycles, plus the expected beat queue.
  beat_t   q[$];
  mphase_t ph = M_IDLE;
  int      left = 0;
  bit      m_full = 0, m_lastf = 0, m_prev = 0, m_ovr = 0, exp_missed = 0;
  int      miss_total = 0, burst_total = 0, tlast_seen = 0;

  task automatic model_step();
    bit    edge_s, full0, acc;
    beat_t b;
    edge_s = trig && !m_prev;
    if (rst) begin
      ph = M_IDLE; left = 0; m_full = 0; m_lastf = 0; m_prev = 0;
      m_ovr = 0; exp_missed = 0; miss_total = 0; burst_total = 0;
      q.delete();
    end else begin
      m_prev     = trig;
      exp_missed = edge_s && (ph != M_IDLE);
      if (exp_missed) miss_total++;
      full0 = m_full;
      acc   = m_full && m_rdy;
      if (acc) begin
        if (m_lastf) burst_total++;
        m_full = 0; m_lastf = 0;
      end
      case (ph)
        M_IDLE: if (edge_s && en) begin
          if (DLY > 0) begin ph = M_SKIP; left = DLY; end
          else begin ph = M_TAKE; left = SPT; end
        end
        M_SKIP: if (s_vld) begin
          left--;
          if (left == 0) begin ph = M_TAKE; left = SPT; end
        end
        M_TAKE: if (s_vld) begin
          if (full0 && !acc) begin
            if (q.size() > 0) b = q.pop_back();
            m_full = 0; m_lastf = 0; m_ovr = 1;
            ph = M_REST; left = HOLD;
          end else begin
            b.dat  = OW'(s_dat);
            b.last = (left == 1);
            q.push_back(b);
            m_full = 1; m_lastf = b.last;
            left--;
            if (left == 0) begin ph = M_REST; left = HOLD; end
          end
        end
        M_REST: if (!full0) begin
          left--;
          if (left == 0) ph = M_IDLE;
        end
        default: ph = M_IDLE;
      endcase
    end
    chk("tvalid", 64'(m_vld), 64'(m_full));
    chk("tlast", 64'(m_last), 64'(m_full && m_lastf));
    chk("busy", 64'(busy), 64'((ph != M_IDLE) || m_full));
    chk("trig_missed", 64'(trig_missed), 64'(exp_missed));
    chk("overrun", 64'(overrun), 64'(m_ovr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  // Monitor: a beat presented with tready high is transferred at the coming edge.
  always @(negedge clk) begin
    beat_t b;
    if (!rst && m_vld && m_rdy) begin
      chk("beat_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        b = q.pop_front();
        chk("beat_data", 64'(m_dat), 64'(b.dat));
        chk("beat_last", 64'(m_last), 64'(b.last));
        if (m_last) tlast_seen++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; en = 0; trig = 0; s_vld = 0; s_dat = '0; m_rdy = 1;
    repeat (3) tick();
    chk("rst_tvalid", 64'(m_vld), 64'd0);
    chk("rst_tlast", 64'(m_last), 64'd0);
    chk("rst_tdata", 64'(m_dat), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("s_tready", 64'(s_rdy), 64'd1);
    chk("tstrb", 64'(m_strb), 64'hF);
    rst = 0;

    // nominal burst, continuous input
    en = 1; s_vld = 1;
    for (int c = 0; c < 60; c++) begin s_dat = IW'($urandom); trig = (c == 10); tick(); end
    // second edge inside the burst
    for (int c = 0; c < 60; c++) begin s_dat = IW'($urandom); trig = (c == 2) || (c == 9); tick(); end
    // edge while disarmed
    en = 0;
    for (int c = 0; c < 30; c++) begin s_dat = IW'($urandom); trig = (c == 3); tick(); end
    chk("disarmed_idle", 64'(busy), 64'd0);
    en = 1;
    // input gaps with a single-cycle tready drop
    for (int c = 0; c < 60; c++) begin
      s_dat = IW'($urandom); s_vld = (c % 2 == 0); m_rdy = (c != 12); trig = (c == 2); tick();
    end
    // tready low across consecutive beats -> overrun
    for (int c = 0; c < 60; c++) begin
      s_dat = IW'($urandom); s_vld = 1; m_rdy = !(c >= 9 && c <= 11); trig = (c == 2); tick();
    end
    chk("overrun_sticky", 64'(overrun), 64'd1);
    // reset mid-burst, then a fresh burst
    m_rdy = 1;
    for (int c = 0; c < 60; c++) begin
      s_dat = IW'($urandom); trig = (c == 2) || (c == 30); rst = (c == 10); tick();
      if (c == 10) begin
        chk("midrst_tvalid", 64'(m_vld), 64'd0);
        chk("midrst_tdata", 64'(m_dat), 64'd0);
        chk("midrst_overrun", 64'(overrun), 64'd0);
      end
    end
    rst = 0;
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      s_dat = IW'($urandom);
      s_vld = ($urandom_range(9) < 8);
      m_rdy = ($urandom_range(15) != 0);
      if ($urandom_range(7) == 0) trig = !trig;
      if ($urandom_range(49) == 0) en = !en;
      rst = ($urandom_range(999) == 0);
      tick();
    end
    rst = 0; trig = 0; m_rdy = 1;
    repeat (100) tick();
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("bursts_delivered", 64'(tlast_seen > 5), 64'd1);
`ifdef TRIGGER_CAPTURE_STATS_EN
    chk("burst_count", 64'(burst_count), 64'(burst_total[15:0]));
    chk("missed_count", 64'(missed_count), 64'((miss_total > 65535) ? 65535 : miss_total));
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/trigger_capture.md
Name: trigger_capture

Overview:
- Upstream stage of the trigger averager.
- Watches a free-running ADC AXI-Stream and a trigger input.
- On each armed trigger edge, forwards exactly SAMPLES_PER_TRIGGER consecutive samples as one burst, with tlast on the final sample.
- Between bursts it forces m00_axis_tvalid low for a guaranteed holdoff gap, so the downstream averager's tvalid rising-edge detection sees each burst start.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32: ADC sample width.
- C_M00_AXIS_TDATA_WIDTH, 32: output width; must be >= C_S00_AXIS_TDATA_WIDTH; samples are zero-extended.
- SAMPLES_PER_TRIGGER, 1024: beats per burst, range 2..65535.
- TRIG_DELAY, 0: valid input beats discarded after the trigger before capture starts, range 0..65535.
- HOLDOFF_CYCLES, 16: idle clock cycles with the output register empty after a burst, before re-arm; minimum 1.

Ports:
- s00_axis_aclk, in, 1: single clock for both streams.
- s00_axis_areset, in, 1: synchronous, active-high reset.
- s00_axis_tvalid, in, 1: ADC sample valid.
- s00_axis_tdata, in, C_S00_AXIS_TDATA_WIDTH: ADC sample.
- s00_axis_tready, out, 1: tied 1; the ADC cannot be stalled.
- trig_in, in, 1: trigger level, synchronous to clock.
- enable, in, 1: arms capture while high.
- m00_axis_tready, in, 1: downstream ready.
- m00_axis_tvalid, out, 1: burst sample valid.
- m00_axis_tlast, out, 1: final sample of burst.
- m00_axis_tdata, out, C_M00_AXIS_TDATA_WIDTH: sample.
- m00_axis_tstrb, out, C_M00_AXIS_TDATA_WIDTH/8: all ones.
- busy, out, 1: state != IDLE or output register full.
- trig_missed, out, 1: one-cycle pulse when a trigger edge is ignored.
- overrun, out, 1: sticky; cleared only by reset.

Behaviour:
- Clock and reset: one clock, s00_axis_aclk. Reset s00_axis_areset is synchronous and active-high. Reset mid-operation aborts any burst.
- Reset values: state IDLE; all counters 0; trig_prev 0; m00_axis_tvalid 0; m00_axis_tlast 0; m00_axis_tdata 0; busy 0; trig_missed 0; overrun 0.
- Trigger edge: trig_in=1 and trig_prev=0, sampled every cycle.
- IDLE:
  - Edge with enable=1 -> DELAY if TRIG_DELAY>0, else CAPTURE.
  - Edge with enable=0 is ignored, with no trig_missed pulse.
- DELAY: counts s00 valid beats. After TRIG_DELAY beats -> CAPTURE; the beat that completes the count is discarded.
- CAPTURE:
  - Each s00 beat (tvalid=1) is loaded into the output register: m00_axis_tvalid=1 and m00_axis_tdata=zero-extended sample on the next cycle. Latency is 1 cycle.
  - First captured beat: the first valid beat in cycle T+1 or later, where T is the edge cycle.
  - Beat index SAMPLES_PER_TRIGGER-1 also sets m00_axis_tlast, then -> HOLDOFF.
- Output register: holds its value while m00_axis_tvalid=1 and m00_axis_tready=0. It clears on handshake unless a new beat loads it in the same cycle (simultaneous accept and load is legal).
- Overrun: an s00 beat arrives in CAPTURE while the register is full and not being accepted. Then:
  - the beat is dropped;
  - overrun is set;
  - m00_axis_tvalid and m00_axis_tlast clear on the next cycle (burst aborted, no tlast emitted);
  - state -> HOLDOFF.
- HOLDOFF: the counter increments only while the output register is empty. After HOLDOFF_CYCLES counted cycles -> IDLE, with counters reset.
- Ignored triggers: an edge arriving in DELAY, CAPTURE or HOLDOFF is ignored and pulses trig_missed for 1 cycle.
- enable deasserted mid-burst: the burst completes normally; enable gates arming only.
- Counters are 16 bit; none wraps, since the parameter ranges are bounded.

Optional Feature:
- Macro: TRIGGER_CAPTURE_STATS_EN.
- Defined:
  - Adds output burst_count[15:0], incremented when a tlast handshake completes. It wraps 0xFFFF->0.
  - Adds output missed_count[15:0], incremented on each trig_missed pulse. It saturates at 0xFFFF.
  - Both reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package trigger_capture_pkg holds:
  - the state_t enum {IDLE, DELAY, CAPTURE, HOLDOFF};
  - the counter width constant CNT_W=16.
- One natural sub-module: axis_out_reg. It is the 1-deep output register with load/accept/abort and overrun detect, reusable by other stages.

Test Plan:
- Nominal burst: SAMPLES_PER_TRIGGER=8, TRIG_DELAY=0, continuous tvalid with data=n, tready=1, trigger edge at cycle 10. Expect 8 contiguous m00 beats carrying the samples from cycles 11..18, tlast on the 8th, then tvalid low for at least 16 cycles.
- Delay: TRIG_DELAY=3. Expect the first output to equal the 4th input beat after the edge; gaps in s00 tvalid stretch both DELAY and CAPTURE.
- Retrigger and arming: a second edge during CAPTURE gives one trig_missed pulse and burst length unchanged; an edge with enable=0 in IDLE gives no burst and no pulse.
- Backpressure:
  - tready low for 1 cycle with input gaps: no data loss, 8 beats delivered.
  - tready low across 2 consecutive input beats: overrun=1, tvalid drops, no tlast, re-arm after holdoff.
- Reset mid-burst after 4 beats: all outputs 0 on the next cycle; a new trigger yields a full 8-beat burst.
- With TRIGGER_CAPTURE_STATS_EN: 3 bursts and 2 missed edges give burst_count=3 and missed_count=2.
